// File: rtl/cpu_result_checker.sv
// Self-check monitor for the cpu: scores (num_inst, output_port) against a loadable
// table of expected pairs and reports pass/fail/miss/timeout counts plus the first failure.
module cpu_result_checker #(
    parameter int WORD_SIZE  = 16,
    parameter int NUM_TEST   = 64,
    parameter int IDX_W      = 6,
    parameter int MAX_CYCLES = 10000,
    parameter int CYC_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tbl_we,
    input  logic [IDX_W-1:0]     tbl_addr,
    input  logic [WORD_SIZE-1:0] tbl_inst,
    input  logic [WORD_SIZE-1:0] tbl_ans,
    input  logic [IDX_W:0]       num_tests,
    input  logic                 stop_on_fail,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] num_inst,
    input  logic [WORD_SIZE-1:0] output_port,
    input  logic                 is_halted,
    output logic                 busy,
    output logic                 done,
    output logic                 all_pass,
    output logic                 timeout,
    output logic [IDX_W:0]       pass_cnt,
    output logic [IDX_W:0]       fail_cnt,
    output logic [IDX_W:0]       miss_cnt,
    output logic [IDX_W-1:0]     fail_idx,
    output logic [WORD_SIZE-1:0] fail_value,
    output logic [CYC_W-1:0]     cycle_cnt
);

    // Control semantics: start is a single-cycle pulse, accepted only outside RUN;
    // tbl_we is a write strobe accepted only outside RUN, and may coincide with start.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDX_W:0]   NUM_TEST_W = (IDX_W+1)'(NUM_TEST);
    localparam logic [CYC_W-1:0] LAST_CYC   = CYC_W'(MAX_CYCLES - 1);

    state_t state, state_next;

    logic [WORD_SIZE-1:0] inst_mem [NUM_TEST];
    logic [WORD_SIZE-1:0] ans_mem  [NUM_TEST];

    logic [IDX_W:0]       n, idx, idx_next, n_clamped;
    logic [IDX_W:0]       pass_next, fail_next, miss_next;
    logic                 stop_lat;
    logic [WORD_SIZE-1:0] entry_inst, entry_ans;
    logic                 start_run, in_range, chk_hit, chk_fail, chk_skip;
    logic                 hit_limit, end_run;
    logic [CYC_W-1:0]     cyc_next;

    // Table storage has no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (tbl_we && state != RUN) begin
            inst_mem[tbl_addr] <= tbl_inst;
            ans_mem[tbl_addr]  <= tbl_ans;
        end
    end

    assign entry_inst = inst_mem[idx[IDX_W-1:0]];
    assign entry_ans  = ans_mem[idx[IDX_W-1:0]];

    always_comb begin
        n_clamped = (num_tests > NUM_TEST_W) ? NUM_TEST_W : num_tests;
        start_run = start && (state != RUN);
        in_range  = idx < n;
        chk_hit   = in_range && (num_inst == entry_inst);
        chk_fail  = chk_hit && (output_port != entry_ans);
        chk_skip  = in_range && (num_inst > entry_inst);
        idx_next  = idx + {{IDX_W{1'b0}}, chk_hit | chk_skip};
        pass_next = pass_cnt + {{IDX_W{1'b0}}, chk_hit & ~chk_fail};
        fail_next = fail_cnt + {{IDX_W{1'b0}}, chk_fail};
        cyc_next  = cycle_cnt + CYC_W'(1);
        hit_limit = (cyc_next == LAST_CYC);
        end_run   = is_halted | (chk_fail & stop_lat) | hit_limit;
        miss_next = miss_cnt + {{IDX_W{1'b0}}, chk_skip};
        // Entries still pending when the run ends can never be checked.
        if (end_run) begin
            miss_next = miss_next + (n - idx_next);
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start)   state_next = RUN;
            RUN:     if (end_run) state_next = DONE;
            DONE:    if (start)   state_next = RUN;
            default:              state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n          <= '0;
            stop_lat   <= 1'b0;
            idx        <= '0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            miss_cnt   <= '0;
            fail_idx   <= '0;
            fail_value <= '0;
            cycle_cnt  <= '0;
            timeout    <= 1'b0;
        end else if (start_run) begin
            n          <= n_clamped;
            stop_lat   <= stop_on_fail;
            idx        <= '0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            miss_cnt   <= '0;
            fail_idx   <= '0;
            fail_value <= '0;
            cycle_cnt  <= '0;
            timeout    <= 1'b0;
        end else if (state == RUN) begin
            idx       <= idx_next;
            pass_cnt  <= pass_next;
            fail_cnt  <= fail_next;
            miss_cnt  <= miss_next;
            cycle_cnt <= cyc_next;
            if (chk_fail && fail_cnt == '0) begin
                fail_idx   <= idx[IDX_W-1:0];
                fail_value <= output_port;
            end
            if (hit_limit) begin
                timeout <= 1'b1;
            end
        end
    end

    assign busy     = (state == RUN);
    assign done     = (state == DONE);
    assign all_pass = done && (pass_cnt == n) && (fail_cnt == '0);

endmodule

// File: tb/tb_cpu_result_checker.sv
// Randomised and directed bench for cpu_result_checker, scored against a
// whole-run reference model kept in plain integer arithmetic.
module tb_cpu_result_checker;

    localparam int WS = 16;
    localparam int NT = 8;
    localparam int IW = 3;
    localparam int MC = 20;
    localparam int CW = 8;
    localparam int TL = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic          tbl_we = 1'b0;
    logic [IW-1:0] tbl_addr = '0;
    logic [WS-1:0] tbl_inst = '0;
    logic [WS-1:0] tbl_ans = '0;
    logic [IW:0]   num_tests = '0;
    logic          stop_on_fail = 1'b0;
    logic          start = 1'b0;
    logic [WS-1:0] num_inst = '0;
    logic [WS-1:0] output_port = '0;
    logic          is_halted = 1'b0;
    logic          busy, done, all_pass, timeout;
    logic [IW:0]   pass_cnt, fail_cnt, miss_cnt;
    logic [IW-1:0] fail_idx;
    logic [WS-1:0] fail_value;
    logic [CW-1:0] cycle_cnt;

    cpu_result_checker #(
        .WORD_SIZE(WS), .NUM_TEST(NT), .IDX_W(IW), .MAX_CYCLES(MC), .CYC_W(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_inst(tbl_inst), .tbl_ans(tbl_ans),
        .num_tests(num_tests), .stop_on_fail(stop_on_fail), .start(start),
        .num_inst(num_inst), .output_port(output_port), .is_halted(is_halted),
        .busy(busy), .done(done), .all_pass(all_pass), .timeout(timeout),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .miss_cnt(miss_cnt),
        .fail_idx(fail_idx), .fail_value(fail_value), .cycle_cnt(cycle_cnt)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    int t_inst [NT];
    int t_ans  [NT];
    int tr_inst [TL];
    int tr_out  [TL];
    bit tr_halt [TL];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Whole-run model: walks the trace one cycle at a time over the sorted table.
    task automatic model_run(input int n, input bit stop);
        int idx = 0, pass = 0, fail = 0, miss = 0, fidx = 0, fval = 0, cyc = 0;
        bit tmo = 0;
        for (int k = 0; k < TL; k++) begin
            bit fail_now = 0;
            cyc++;
            if (idx < n) begin
                if (tr_inst[k] == t_inst[idx]) begin
                    if (tr_out[k] == t_ans[idx]) pass++;
                    else begin
                        if (fail == 0) begin
                            fidx = idx;
                            fval = tr_out[k];
                        end
                        fail++;
                        fail_now = 1;
                    end
                    idx++;
                end else if (tr_inst[k] > t_inst[idx]) begin
                    miss++;
                    idx++;
                end
            end
            if (cyc == MC - 1) tmo = 1;
            if (tr_halt[k] || (stop && fail_now) || tmo) begin
                miss += n - idx;
                break;
            end
        end
        exp_q.push_back(32'(cyc));
        exp_q.push_back(32'(pass));
        exp_q.push_back(32'(fail));
        exp_q.push_back(32'(miss));
        exp_q.push_back(32'(tmo));
        exp_q.push_back(32'(fidx));
        exp_q.push_back(32'(fval));
        exp_q.push_back(32'((pass == n) && (fail == 0)));
    endtask

    function automatic int ans_for(input int v, input int n);
        for (int i = 0; i < n; i++) begin
            if (t_inst[i] == v) return t_ans[i];
        end
        return int'($urandom_range(0, 65535));
    endfunction

    // ---------------- driver tasks ----------------
    task automatic write_entry(input int a, input int inst, input int ans);
        @(negedge clk);
        tbl_we = 1'b1;
        tbl_addr = IW'(a);
        tbl_inst = WS'(inst);
        tbl_ans = WS'(ans);
        t_inst[a] = inst;
        t_ans[a] = ans;
        @(negedge clk);
        tbl_we = 1'b0;
    endtask

    task automatic build_ramp(input int top, input int halt_at, input int bad_inst, input int bad_val);
        for (int k = 0; k < TL; k++) begin
            tr_inst[k] = (k < top) ? k : top;
            tr_out[k] = (tr_inst[k] == bad_inst) ? bad_val : ans_for(tr_inst[k], 3);
            tr_halt[k] = (k == halt_at);
        end
    endtask

    task automatic run_trace(input string name, input int nt, input bit stop,
                             input bit co_write, input int co_a, input int co_i, input int co_v,
                             input bit wr_in_run);
        int n;
        int edges;
        n = (nt > NT) ? NT : nt;
        model_run(n, stop);
        @(negedge clk);
        num_tests = (IW+1)'(nt);
        stop_on_fail = stop;
        start = 1'b1;
        if (co_write) begin
            tbl_we = 1'b1;
            tbl_addr = IW'(co_a);
            tbl_inst = WS'(co_i);
            tbl_ans = WS'(co_v);
        end
        @(negedge clk);
        start = 1'b0;
        tbl_we = 1'b0;
        edges = 0;
        while (busy && edges < TL) begin
            num_inst = WS'(tr_inst[edges]);
            output_port = WS'(tr_out[edges]);
            is_halted = tr_halt[edges];
            if (wr_in_run && edges == 0) begin
                tbl_we = 1'b1;
                tbl_addr = IW'((n > 0) ? n - 1 : 0);
                tbl_inst = '0;
                tbl_ans = WS'($urandom_range(0, 65535));
            end
            @(negedge clk);
            tbl_we = 1'b0;
            edges++;
        end
        is_halted = 1'b0;
        begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check_eq({name, ".edges"}, 32'(edges), e);
            check_eq({name, ".cycle_cnt"}, 32'(cycle_cnt), e);
            check_eq({name, ".done"}, 32'(done), 32'd1);
            check_eq({name, ".busy"}, 32'(busy), 32'd0);
            check_eq({name, ".pass_cnt"}, 32'(pass_cnt), exp_q.pop_front());
            check_eq({name, ".fail_cnt"}, 32'(fail_cnt), exp_q.pop_front());
            check_eq({name, ".miss_cnt"}, 32'(miss_cnt), exp_q.pop_front());
            check_eq({name, ".timeout"}, 32'(timeout), exp_q.pop_front());
            check_eq({name, ".fail_idx"}, 32'(fail_idx), exp_q.pop_front());
            check_eq({name, ".fail_value"}, 32'(fail_value), exp_q.pop_front());
            check_eq({name, ".all_pass"}, 32'(all_pass), exp_q.pop_front());
        end
    endtask

    task automatic check_all_zero(input string name);
        check_eq({name, ".busy"}, 32'(busy), 32'd0);
        check_eq({name, ".done"}, 32'(done), 32'd0);
        check_eq({name, ".all_pass"}, 32'(all_pass), 32'd0);
        check_eq({name, ".timeout"}, 32'(timeout), 32'd0);
        check_eq({name, ".pass_cnt"}, 32'(pass_cnt), 32'd0);
        check_eq({name, ".fail_cnt"}, 32'(fail_cnt), 32'd0);
        check_eq({name, ".miss_cnt"}, 32'(miss_cnt), 32'd0);
        check_eq({name, ".fail_idx"}, 32'(fail_idx), 32'd0);
        check_eq({name, ".fail_value"}, 32'(fail_value), 32'd0);
        check_eq({name, ".cycle_cnt"}, 32'(cycle_cnt), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        for (int i = 0; i < NT; i++) begin
            t_inst[i] = 0;
            t_ans[i] = 0;
        end
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;

        write_entry(0, 3, 16'h0000);
        write_entry(1, 5, 16'h0001);
        write_entry(2, 7, 16'hFFFE);

        // All entries match, then halt.
        build_ramp(7, 8, -1, 0);
        run_trace("t1", 3, 0, 0, 0, 0, 0, 0);
        check_eq("t1.lit_pass", 32'(pass_cnt), 32'd3);
        check_eq("t1.lit_all_pass", 32'(all_pass), 32'd1);

        // Wrong answer at entry 1, run continues.
        build_ramp(7, 8, 5, 16'h0002);
        run_trace("t2", 3, 0, 0, 0, 0, 0, 0);
        check_eq("t2.lit_fail_idx", 32'(fail_idx), 32'd1);
        check_eq("t2.lit_fail_value", 32'(fail_value), 32'h0002);
        check_eq("t2.lit_pass", 32'(pass_cnt), 32'd2);

        // Same mismatch, stop at first failure.
        build_ramp(7, 8, 5, 16'h0002);
        run_trace("t3", 3, 1, 0, 0, 0, 0, 0);
        check_eq("t3.lit_pass", 32'(pass_cnt), 32'd1);
        check_eq("t3.lit_miss", 32'(miss_cnt), 32'd1);

        // num_inst jumps 3 -> 9: entries 5 and 7 both missed.
        build_ramp(7, 6, -1, 0);
        for (int k = 4; k < TL; k++) tr_inst[k] = 9;
        run_trace("t4", 3, 0, 0, 0, 0, 0, 0);
        check_eq("t4.lit_miss", 32'(miss_cnt), 32'd2);

        // Never halts: cycle budget expires.
        build_ramp(4, -1, -1, 0);
        run_trace("t5", 3, 0, 0, 0, 0, 0, 0);
        check_eq("t5.lit_timeout", 32'(timeout), 32'd1);
        check_eq("t5.lit_cycle_cnt", 32'(cycle_cnt), 32'd19);
        check_eq("t5.lit_miss", 32'(miss_cnt), 32'd2);

        // Reset mid-run, then rerun against the retained table.
        build_ramp(7, 8, -1, 0);
        @(negedge clk);
        num_tests = 3;
        stop_on_fail = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            num_inst = WS'(tr_inst[k]);
            output_port = WS'(tr_out[k]);
            @(negedge clk);
        end
        check_eq("t6.pre_pass", 32'(pass_cnt), 32'd1);
        check_eq("t6.pre_busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1 check_all_zero("t6.rst");
        @(negedge clk);
        reset_n = 1'b1;
        run_trace("t6.rerun", 3, 0, 0, 0, 0, 0, 0);
        check_eq("t6.lit_pass", 32'(pass_cnt), 32'd3);

        // Randomised runs over a full sorted table.
        for (int r = 0; r < 40; r++) begin
            int v, nt, co_a, co_v, cur, h;
            bit stop, co, wr;
            string name;
            name = $sformatf("rnd%0d", r);
            v = $urandom_range(1, 3);
            for (int i = 0; i < NT; i++) begin
                write_entry(i, v, $urandom_range(0, 65535));
                v += $urandom_range(1, 3);
            end
            co = $urandom_range(0, 1);
            co_a = $urandom_range(0, NT - 1);
            co_v = $urandom_range(0, 65535);
            if (co) t_ans[co_a] = co_v;
            nt = $urandom_range(0, 15);
            stop = ($urandom_range(0, 3) == 0);
            wr = $urandom_range(0, 1);
            h = $urandom_range(2, 30);
            if (h == MC - 2) h = MC - 3;
            cur = 0;
            for (int k = 0; k < TL; k++) begin
                int s;
                s = $urandom_range(0, 3);
                cur += (s == 3) ? 2 : ((s == 0) ? 0 : 1);
                tr_inst[k] = cur;
                tr_out[k] = ans_for(cur, NT);
                if ($urandom_range(0, 4) == 0) tr_out[k] = tr_out[k] ^ 1;
                tr_halt[k] = (k == h);
            end
            run_trace(name, nt, stop, co, co_a, t_inst[co_a], co_v, wr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
